config_chain_loader: RTL and testbench

CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

---
 rtl/config_chain_loader.sv | 198 +++++++++++++++++++
 tb/tb_config_chain_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
// -----------------------------------------------------------------------------
// config_chain_loader
//
// Streams configuration words into a serial scan chain of CHAIN_LEN flops.
// Each accepted word is held in a one-word buffer and shifted out LSB first,
// one bit per cycle while sc_en is high. Exactly CHAIN_LEN bits are shifted
// per load; surplus bits of the final word are discarded. A one-cycle done
// pulse follows the last shift.
//
// Handshake: a word transfers on a rising edge where wvalid && wready. The
// producer may hold wvalid for any number of cycles. wready does not depend
// on wvalid, so there is no combinational loop through the producer.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      asynchronous, active-low reset
//   start      single-cycle load request (ignored while busy)
//   abort      cancel any load in progress (wins over start and acceptance)
//   wvalid     configuration word valid
//   wdata      configuration word, bit 0 shifted first
//   wready     buffer can take a word this cycle
//   sc_en      chain shift enable
//   sc_dout    serial data to the chain head (zero when sc_en is low)
//   busy       high in LOAD and DONE
//   done       one-cycle pulse after the final chain bit
//   state_dbg  current FSM state (0 IDLE, 1 LOAD, 2 DONE)
// -----------------------------------------------------------------------------
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              wvalid,
  input  logic [WORD_W-1:0] wdata,
  output logic              wready,
  output logic              sc_en,
  output logic              sc_dout,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [31:0]      WORD_W_U    = 32'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q,     state_d;
  logic [WORD_W-1:0]  buf_q,       buf_d;
  logic               buf_vld_q,   buf_vld_d;   // buffer holds an unshifted bit
  logic [IDX_W-1:0]   bit_idx_q,   bit_idx_d;   // next bit of buf_q to shift
  logic [IDX_W-1:0]   buf_last_q,  buf_last_d;  // last used bit of this word
  logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d; // bits shifted so far
  logic [CNT_W-1:0]   req_cnt_q,   req_cnt_d;   // bits covered by accepted words

  logic               last_shift;
  logic               final_shift;
  logic               accept;
  logic [31:0]        rem_bits;
  logic [31:0]        take_bits;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      buf_vld_q   <= 1'b0;
      bit_idx_q   <= '0;
      buf_last_q  <= '0;
      shift_cnt_q <= '0;
      req_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_vld_q   <= buf_vld_d;
      bit_idx_q   <= bit_idx_d;
      buf_last_q  <= buf_last_d;
      shift_cnt_q <= shift_cnt_d;
      req_cnt_q   <= req_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_vld_d   = buf_vld_q;
    bit_idx_d   = bit_idx_q;
    buf_last_d  = buf_last_q;
    shift_cnt_d = shift_cnt_q;
    req_cnt_d   = req_cnt_q;

    sc_en       = 1'b0;
    sc_dout     = 1'b0;
    wready      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    last_shift  = 1'b0;
    final_shift = 1'b0;
    accept      = 1'b0;

    // Bits still to be requested, and how many of them the next word covers.
    // Only the final word of a load can be short.
    rem_bits  = 32'(CHAIN_LEN_C - req_cnt_q);
    take_bits = (rem_bits >= WORD_W_U) ? WORD_W_U : rem_bits;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d     = S_LOAD;
          buf_d       = '0;
          buf_vld_d   = 1'b0;
          bit_idx_d   = '0;
          buf_last_d  = '0;
          shift_cnt_d = '0;
          req_cnt_d   = '0;
        end
      end

      S_LOAD: begin
        busy        = 1'b1;
        sc_en       = buf_vld_q;
        sc_dout     = buf_vld_q ? buf_q[bit_idx_q] : 1'b0;
        last_shift  = buf_vld_q && (bit_idx_q == buf_last_q);
        final_shift = buf_vld_q && (shift_cnt_q == CHAIN_LEN_C - CNT_W'(1));
        // Accepting on the last-bit cycle refills the buffer in the same edge,
        // so consecutive words shift without a bubble.
        wready      = (req_cnt_q != CHAIN_LEN_C) && (!buf_vld_q || last_shift);
        accept      = wready && wvalid && !abort;

        if (abort) begin
          state_d     = S_IDLE;
          buf_d       = '0;
          buf_vld_d   = 1'b0;
          bit_idx_d   = '0;
          buf_last_d  = '0;
          shift_cnt_d = '0;
          req_cnt_d   = '0;
        end else begin
          if (sc_en) begin
            shift_cnt_d = shift_cnt_q + CNT_W'(1);
            bit_idx_d   = bit_idx_q + IDX_W'(1);
            if (last_shift) begin
              buf_vld_d = 1'b0;
            end
          end
          if (accept) begin
            buf_d      = wdata;
            buf_vld_d  = 1'b1;
            bit_idx_d  = '0;
            buf_last_d = IDX_W'(take_bits - 32'd1);
            req_cnt_d  = req_cnt_q + CNT_W'(take_bits);
          end
          // The final shift always empties the buffer and no word can be
          // accepted alongside it, since every bit has already been requested.
          if (final_shift) begin
            state_d   = S_DONE;
            buf_d     = '0;
            buf_vld_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        busy        = 1'b1;
        done        = !abort;
        state_d     = S_IDLE;
        buf_d       = '0;
        buf_vld_d   = 1'b0;
        bit_idx_d   = '0;
        buf_last_d  = '0;
        shift_cnt_d = '0;
        req_cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_config_chain_loader
//
// Three loader instances share one stimulus bus: CHAIN_LEN 12, 16 and 1, all
// with 8-bit words. Every scenario starts from a reset pulse; `sel` picks
// which instance's outputs are observed. Inputs change on the falling edge
// and outputs are sampled 1 ns later, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_config_chain_loader;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       abort;
  logic       wvalid;
  logic [7:0] wdata;

  logic       a_wready, a_sc_en, a_sc_dout, a_busy, a_done;
  logic       b_wready, b_sc_en, b_sc_dout, b_busy, b_done;
  logic       c_wready, c_sc_en, c_sc_dout, c_busy, c_done;
  logic [1:0] a_state, b_state, c_state;

  config_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut12 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wvalid(wvalid), .wdata(wdata), .wready(a_wready), .sc_en(a_sc_en),
    .sc_dout(a_sc_dout), .busy(a_busy), .done(a_done), .state_dbg(a_state)
  );

  config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wvalid(wvalid), .wdata(wdata), .wready(b_wready), .sc_en(b_sc_en),
    .sc_dout(b_sc_dout), .busy(b_busy), .done(b_done), .state_dbg(b_state)
  );

  config_chain_loader #(.CHAIN_LEN(1), .WORD_W(8)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wvalid(wvalid), .wdata(wdata), .wready(c_wready), .sc_en(c_sc_en),
    .sc_dout(c_sc_dout), .busy(c_busy), .done(c_done), .state_dbg(c_state)
  );

  // Observed instance
  int         sel;
  logic       m_wready, m_sc_en, m_sc_dout, m_busy, m_done;
  logic [1:0] m_state;

  always_comb begin
    m_wready = a_wready; m_sc_en = a_sc_en; m_sc_dout = a_sc_dout;
    m_busy = a_busy; m_done = a_done; m_state = a_state;
    if (sel == 1) begin
      m_wready = b_wready; m_sc_en = b_sc_en; m_sc_dout = b_sc_dout;
      m_busy = b_busy; m_done = b_done; m_state = b_state;
    end else if (sel == 2) begin
      m_wready = c_wready; m_sc_en = c_sc_en; m_sc_dout = c_sc_dout;
      m_busy = c_busy; m_done = c_done; m_state = c_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int       checks = 0;
  int       errors = 0;
  logic     exp_q[$];
  logic     got_q[$];
  int       shift_cyc[$];
  int       done_cyc[$];
  int       cyc;
  int       accepts;
  logic     last_wready;
  logic     post_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    exp_q.delete();
    got_q.delete();
    shift_cyc.delete();
    done_cyc.delete();
    cyc     = 0;
    accepts = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One clock cycle: drive inputs, sample the observed instance, log activity.
  task automatic step(input logic s, input logic a, input logic v, input logic [7:0] d);
    @(negedge clk);
    start  = s;
    abort  = a;
    wvalid = v;
    wdata  = d;
    #1;
    last_wready = m_wready;
    if (m_sc_en) begin
      got_q.push_back(m_sc_dout);
      shift_cyc.push_back(cyc);
    end
    if (m_done) done_cyc.push_back(cyc);
    if (m_wready && v && !a) accepts++;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    wvalid = 1'b0;
    wdata  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Full load of nw words. `gap` cycles of wvalid=0 are inserted before the
  // second word, counted from the first cycle that word could be taken.
  // `spam` keeps start asserted for the whole load.
  task automatic run_load(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                          input int gap, input logic spam);
    int guard;
    int acc_before;
    logic [7:0] wv;
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < nw; k++) begin
      wv = (k == 0) ? w0 : w1;
      if (k > 0 && gap > 0) begin
        guard = 0;
        do begin
          step(spam, 1'b0, 1'b0, 8'h00);
          guard++;
        end while (!last_wready && guard < 40);
        repeat (gap - 1) step(spam, 1'b0, 1'b0, 8'h00);
      end
      guard      = 0;
      acc_before = accepts;
      do begin
        step(spam, 1'b0, 1'b1, wv);
        guard++;
      end while (accepts == acc_before && guard < 40);
    end
    guard = 0;
    while (done_cyc.size() == 0 && guard < 60) begin
      step(spam, 1'b0, 1'b1, 8'hFF);
      guard++;
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    post_busy = m_busy;
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Compare a logged load against the reference bit stream built from words.
  task automatic check_load(input string nm, input int chain_len, input int nw,
                            input logic [7:0] w0, input logic [7:0] w1, input int exp_gap);
    logic [7:0] word;
    int n;
    int span;
    exp_q.delete();
    for (int k = 0; k < chain_len; k++) begin
      word = ((k / 8) == 0) ? w0 : w1;
      exp_q.push_back(word[k % 8]);
    end
    chk({nm, "_shift_count"}, got_q.size(), chain_len);
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_bit%0d", nm, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({nm, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && shift_cyc.size() > 0)
      chk({nm, "_done_pos"}, done_cyc[0], shift_cyc[shift_cyc.size()-1] + 1);
    if (shift_cyc.size() > 0) begin
      span = shift_cyc[shift_cyc.size()-1] - shift_cyc[0] + 1;
      chk({nm, "_gap_total"}, span - shift_cyc.size(), exp_gap);
    end
    if (chain_len > 8 && shift_cyc.size() > 8)
      chk({nm, "_gap_bit7"}, shift_cyc[8] - shift_cyc[7] - 1, exp_gap);
    chk({nm, "_accepts"}, accepts, nw);
    chk({nm, "_idle_after"}, 32'(post_busy), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       s;
    logic       a;
    logic       v;
    logic [7:0] d;
    logic [4:0] exp; // {sc_en, sc_dout, wready, busy, done}
  } vec_t;

  initial begin
    vec_t tbl[16];
    int   guard;

    // CHAIN_LEN 12: 0xA5 then 0x3C, wvalid held high. A5 LSB first is
    // 1,0,1,0,0,1,0,1; the low nibble of 3C is 0,0,1,1.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 5'b00000}; // IDLE, start
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 5'b00110}; // LOAD empty, accept A5
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b11010};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b10010};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b11010};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b10010};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b10010};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b11010};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b10010};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 5'b11110}; // last bit, accept 3C
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'hFF, 5'b10010};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'hFF, 5'b10010};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'hFF, 5'b11010};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 8'hFF, 5'b11010}; // 12th shift
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b00011}; // DONE
    tbl[15] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'b00000}; // IDLE

    sel    = 0;
    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    wvalid = 1'b0;
    wdata  = 8'h00;
    clear_log();

    // Reset state of every instance
    #3;
    chk("reset_dut12", {a_sc_en, a_sc_dout, a_wready, a_busy, a_done, 3'(a_state)}, 8'h00);
    chk("reset_dut16", {b_sc_en, b_sc_dout, b_wready, b_busy, b_done, 3'(b_state)}, 8'h00);
    chk("reset_dut1",  {c_sc_en, c_sc_dout, c_wready, c_busy, c_done, 3'(c_state)}, 8'h00);

    // Table-driven back-to-back load
    apply_reset();
    sel = 0;
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].s, tbl[i].a, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), {m_sc_en, m_sc_dout, m_wready, m_busy, m_done}, tbl[i].exp);
    end

    // Same load through the scoreboard, then with an underflow gap
    apply_reset();
    run_load(2, 8'hA5, 8'h3C, 0, 1'b0);
    check_load("b2b", 12, 2, 8'hA5, 8'h3C, 0);

    apply_reset();
    run_load(2, 8'hA5, 8'h3C, 3, 1'b0);
    check_load("gap3", 12, 2, 8'hA5, 8'h3C, 3);

    // Abort after five shifts on the 16-bit chain, then a clean reload
    apply_reset();
    sel = 1;
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h5A);
    guard = 0;
    while (got_q.size() < 5 && guard < 20) begin
      step(1'b0, 1'b0, 1'b0, 8'h00);
      guard++;
    end
    chk("abort_pre_shifts", got_q.size(), 5);
    step(1'b1, 1'b1, 1'b1, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("abort_idle", {m_sc_en, m_wready, m_busy, m_done, 2'(m_state)}, 6'b000000);
    repeat (4) step(1'b0, 1'b0, 1'b1, 8'hFF);
    chk("abort_no_more_shifts", got_q.size(), 6);
    chk("abort_no_done", done_cyc.size(), 0);
    run_load(2, 8'h96, 8'hC3, 0, 1'b0);
    check_load("reload16", 16, 2, 8'h96, 8'hC3, 0);

    // Asynchronous reset in the middle of a shift
    apply_reset();
    sel = 0;
    clear_log();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b0, 1'b1, 8'h3C);
    chk("areset_pre_shifting", {m_sc_en, m_busy}, 2'b11);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_immediate", {m_sc_en, m_wready, m_busy, m_done, m_sc_dout}, 5'b00000);
    @(negedge clk);
    reset = 1'b1;
    clear_log();
    repeat (5) step(1'b0, 1'b0, 1'b1, 8'h3C);
    chk("areset_no_resume_shifts", got_q.size(), 0);
    chk("areset_no_done", done_cyc.size(), 0);
    chk("areset_stays_idle", {m_busy, m_wready, 2'(m_state)}, 4'b0000);

    // start held throughout LOAD and DONE must not restart the load
    apply_reset();
    run_load(2, 8'hA5, 8'h3C, 0, 1'b1);
    check_load("start_spam", 12, 2, 8'hA5, 8'h3C, 0);

    // Single-flop chain
    apply_reset();
    sel = 2;
    run_load(1, 8'hFE, 8'h00, 0, 1'b0);
    check_load("len1", 1, 1, 8'hFE, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
